// File: rtl/prog_loader.sv
// prog_loader
//   Streams a program into instruction memory, holds the processor core in
//   reset while it is being written, then releases the core and watches it
//   until it parks on a self-branch (normal halt) or runs too long (timeout).
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   start               one-cycle request to begin a load (IDLE/HALTED/TIMEDOUT only)
//   ld_valid/ld_ready   load beat handshake; ld_data is the word, ld_last ends the program
//   im_we/im_waddr/im_wdata  instruction-memory write port, one cycle after each accepted beat
//   core_rstn           active-low core reset, high only while the program runs
//   core_pc/core_instr  fetch address and fetched word, observed for halt detection
//   busy/done/timeout/trunc  status flags
//   cycles              RUN cycles elapsed (saturating, frozen after the run ends)
//   words_loaded        beats accepted in the current load
module prog_loader #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned HALT_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 100000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              core_rstn,
    input  logic [XLEN-1:0]   core_pc,
    input  logic [31:0]       core_instr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              trunc,
    output logic [31:0]       cycles,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned     DEPTH      = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_SLOT  = (ADDR_W + 1)'(DEPTH - 32'd1);
    localparam logic [ADDR_W:0] WORD_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]     HALT_INSTR = 32'h0000_0063;  // beq x0,x0,0
    localparam logic [31:0]     TIMEOUT_C  = 32'(TIMEOUT);
    localparam logic [7:0]      HALT_C     = 8'(HALT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
        S_HALTED   = 3'd3,
        S_TIMEDOUT = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [ADDR_W:0]   words_r;
    logic [31:0]       cycles_r;
    logic [7:0]        halt_cnt_r;
    logic [XLEN-1:0]   prev_pc_r;
    logic              done_r;
    logic              timeout_r;
    logic              trunc_r;
    logic              im_we_r;
    logic [ADDR_W-1:0] im_waddr_r;
    logic [31:0]       im_wdata_r;
    logic              ld_ready_r;
    logic              busy_r;
    logic              core_rstn_r;

    logic              accept_s;
    logic              last_slot_s;
    logic              halt_match_s;
    logic [7:0]        halt_cnt_inc_s;
    logic              halt_hit_s;
    logic [31:0]       cycles_inc_s;
    logic              tmo_hit_s;

    // Per-cycle conditions shared by the FSM and the datapath.
    always_comb begin
        accept_s       = (state_r == S_LOAD) && ld_valid;
        last_slot_s    = (words_r == LAST_SLOT);
        // A halt fetch is the self-branch at the same PC as the previous cycle.
        halt_match_s   = (core_instr == HALT_INSTR) && (core_pc == prev_pc_r);
        halt_cnt_inc_s = halt_cnt_r + 8'd1;
        halt_hit_s     = halt_match_s && (halt_cnt_inc_s == HALT_C);
        if (cycles_r == 32'hFFFF_FFFF) begin
            cycles_inc_s = cycles_r;
        end else begin
            cycles_inc_s = cycles_r + 32'd1;
        end
        tmo_hit_s      = (cycles_inc_s == TIMEOUT_C);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; halt is checked before timeout so it wins a tie.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_HALTED, S_TIMEDOUT: begin
                if (start) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LOAD: begin
                if (accept_s && (ld_last || last_slot_s)) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_RUN: begin
                if (halt_hit_s) begin
                    state_nxt_s = S_HALTED;
                end else if (tmo_hit_s) begin
                    state_nxt_s = S_TIMEDOUT;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs, registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            core_rstn_r <= 1'b0;
        end else begin
            ld_ready_r  <= (state_nxt_s == S_LOAD);
            busy_r      <= (state_nxt_s == S_LOAD) || (state_nxt_s == S_RUN);
            core_rstn_r <= (state_nxt_s == S_RUN);
        end
    end

    // Memory write port, counters and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_pc_r  <= '0;
            im_we_r    <= 1'b0;
            im_waddr_r <= '0;
            im_wdata_r <= 32'd0;
            words_r    <= '0;
            cycles_r   <= 32'd0;
            halt_cnt_r <= 8'd0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            trunc_r    <= 1'b0;
        end else begin
            // Tracked every cycle so the first RUN fetch compares against the last LOAD cycle.
            prev_pc_r <= core_pc;
            im_we_r   <= accept_s;
            if (accept_s) begin
                im_waddr_r <= words_r[ADDR_W-1:0];
                im_wdata_r <= ld_data;
            end
            case (state_r)
                S_IDLE, S_HALTED, S_TIMEDOUT: begin
                    if (start) begin
                        words_r    <= '0;
                        cycles_r   <= 32'd0;
                        halt_cnt_r <= 8'd0;
                        done_r     <= 1'b0;
                        timeout_r  <= 1'b0;
                        trunc_r    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept_s) begin
                        words_r <= words_r + WORD_ONE;
                        trunc_r <= last_slot_s && !ld_last;
                    end
                end
                S_RUN: begin
                    cycles_r   <= cycles_inc_s;
                    halt_cnt_r <= halt_match_s ? halt_cnt_inc_s : 8'd0;
                    done_r     <= halt_hit_s;
                    timeout_r  <= tmo_hit_s && !halt_hit_s;
                end
                default: begin
                    words_r <= words_r;
                end
            endcase
        end
    end

    assign ld_ready     = ld_ready_r;
    assign busy         = busy_r;
    assign core_rstn    = core_rstn_r;
    assign im_we        = im_we_r;
    assign im_waddr     = im_waddr_r;
    assign im_wdata     = im_wdata_r;
    assign done         = done_r;
    assign timeout      = timeout_r;
    assign trunc        = trunc_r;
    assign cycles       = cycles_r;
    assign words_loaded = words_r;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Directed and randomized bench for prog_loader (ADDR_W=2, TIMEOUT=50,
//   HALT_CYCLES=4). Expected run outcomes come from a transaction-level model
//   that scans the planned fetch stream for a halt streak or the timeout.
module tb_prog_loader;

    localparam int          AW        = 2;
    localparam int          DEPTH     = 4;
    localparam int          HC        = 4;
    localparam int          TMO       = 50;
    localparam logic [31:0] HALT_INSN = 32'h0000_0063;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          core_rstn;
    logic [63:0]   core_pc;
    logic [31:0]   core_instr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          trunc;
    logic [31:0]   cycles;
    logic [AW:0]   words_loaded;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] plan_pc [TMO];
    logic [31:0] plan_in [TMO];
    logic [31:0] ld_words [8];
    logic [31:0] exp_wd [$];
    logic [AW-1:0] wr_addr_q [$];
    logic [31:0]   wr_data_q [$];

    prog_loader #(
        .XLEN(64), .ADDR_W(AW), .HALT_CYCLES(HC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .core_rstn(core_rstn), .core_pc(core_pc), .core_instr(core_instr),
        .busy(busy), .done(done), .timeout(timeout), .trunc(trunc),
        .cycles(cycles), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-write monitor.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr_q.push_back(im_waddr);
            wr_data_q.push_back(im_wdata);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] junk();
        return $urandom | 32'h0000_0100;
    endfunction

    // Halt streak completes exactly on RUN cycle h.
    task automatic build_halt(input logic [63:0] prev0, input int h);
        logic [63:0] p;
        p = (h >= HC) ? {$urandom, $urandom} : prev0;
        for (int j = 0; j < TMO; j++) begin
            plan_pc[j] = (j >= h - HC) ? p : {$urandom, $urandom};
            plan_in[j] = (j >= h - HC + 1 && j <= h) ? HALT_INSN : junk();
        end
    endtask

    task automatic build_random();
        for (int j = 0; j < TMO; j++) begin
            plan_pc[j] = ($urandom_range(0, 3) == 0) ? 64'h104 : 64'h100;
            plan_in[j] = ($urandom_range(0, 3) == 0) ? junk() : HALT_INSN;
        end
    endtask

    task automatic build_spin();
        for (int j = 0; j < TMO; j++) begin
            plan_pc[j] = 64'h1000 + 64'(j * 4);
            plan_in[j] = HALT_INSN;
        end
    endtask

    // Scans the fetch plan: HC consecutive same-PC self-branches halt, else TMO cycles time out.
    task automatic run_model(input logic [63:0] prev0, output int last_j,
                             output bit exp_done, output int exp_cyc);
        logic [63:0] prev;
        int streak;
        bit found;
        prev = prev0; streak = 0; found = 1'b0;
        last_j = TMO - 1; exp_done = 1'b0; exp_cyc = TMO;
        for (int j = 0; j < TMO; j++) begin
            if (!found) begin
                if (plan_in[j] == HALT_INSN && plan_pc[j] == prev) streak++;
                else streak = 0;
                prev = plan_pc[j];
                if (streak == HC) begin
                    found = 1'b1; last_j = j; exp_done = 1'b1; exp_cyc = j + 1;
                end
            end
        end
    endtask

    task automatic load_prog(input int n, input bit use_last, input int gap);
        int lim;
        lim = use_last ? n : DEPTH;
        wr_addr_q.delete(); wr_data_q.delete(); exp_wd.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ready", ld_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_crst", core_rstn, 0);
        chk("start_words", words_loaded, 0);
        chk("start_cycles", cycles, 0);
        chk("start_done", done, 0);
        chk("start_tmo", timeout, 0);
        chk("start_trunc", trunc, 0);
        for (int i = 0; i < n; i++) begin
            if (i >= lim) begin
                chk("ready_when_full", ld_ready, 0);
                break;
            end
            chk("ld_ready", ld_ready, 1);
            ld_valid = 1'b1;
            ld_data  = ld_words[i];
            ld_last  = use_last && (i == n - 1);
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            exp_wd.push_back(ld_words[i]);
            chk("words_loaded", words_loaded, 64'(i + 1));
            if (i == lim - 1) begin
                chk("crst_released", core_rstn, 1);
                chk("trunc_flag", trunc, 64'(!use_last));
                chk("busy_run", busy, 1);
            end else begin
                chk("crst_held", core_rstn, 0);
                for (int g = 0; g < gap; g++) begin
                    start = (g == 0);
                    tick();
                    start = 1'b0;
                end
            end
        end
    endtask

    task automatic do_run();
        int last_j;
        bit exp_done;
        int exp_cyc;
        run_model(core_pc, last_j, exp_done, exp_cyc);
        for (int j = 0; j <= last_j; j++) begin
            chk("run_cycles", cycles, 64'(j));
            chk("run_crst", core_rstn, 1);
            core_pc    = plan_pc[j];
            core_instr = plan_in[j];
            start      = (j == 1);
            tick();
            start = 1'b0;
        end
        chk("end_done", done, 64'(exp_done));
        chk("end_timeout", timeout, 64'(!exp_done));
        chk("end_cycles", cycles, 64'(exp_cyc));
        chk("end_busy", busy, 0);
        chk("end_crst", core_rstn, 0);
        chk("end_ready", ld_ready, 0);
        repeat (3) begin
            core_pc    = {$urandom, $urandom};
            core_instr = HALT_INSN;
            tick();
        end
        chk("frozen_cycles", cycles, 64'(exp_cyc));
        chk("held_done", done, 64'(exp_done));
        chk("n_writes", 64'(wr_addr_q.size()), 64'(exp_wd.size()));
        for (int i = 0; i < exp_wd.size() && i < wr_addr_q.size(); i++) begin
            chk("wr_addr", wr_addr_q[i], 64'(i));
            chk("wr_data", wr_data_q[i], exp_wd[i]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, ld_ready, 0);
        chk({tag, "_we"}, im_we, 0);
        chk({tag, "_waddr"}, im_waddr, 0);
        chk({tag, "_wdata"}, im_wdata, 0);
        chk({tag, "_crst"}, core_rstn, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tmo"}, timeout, 0);
        chk({tag, "_trunc"}, trunc, 0);
        chk({tag, "_cycles"}, cycles, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
        core_pc = 64'h40; core_instr = HALT_INSN;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstn = 1'b1;
        repeat (3) tick();
        chk("idle_ready", ld_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_crst", core_rstn, 0);

        // Three back-to-back words, then the core spins on beq at 0x40.
        ld_words[0] = 32'hA0A0_0001; ld_words[1] = 32'hB0B0_0002; ld_words[2] = 32'hC0C0_0003;
        load_prog(3, 1'b1, 0);
        build_halt(core_pc, 3);
        do_run();

        // Same program with gaps between beats; core never halts -> timeout.
        load_prog(3, 1'b1, 2);
        build_spin();
        do_run();

        // Overrun of a four-word memory; halt and timeout land on the same cycle.
        for (int i = 0; i < 5; i++) ld_words[i] = $urandom;
        load_prog(5, 1'b0, 0);
        build_halt(core_pc, TMO - 1);
        do_run();

        // Asynchronous reset in the middle of a run.
        ld_words[0] = $urandom; ld_words[1] = $urandom;
        load_prog(2, 1'b1, 1);
        repeat (5) begin
            core_pc = {$urandom, $urandom}; core_instr = junk();
            tick();
        end
        rstn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #2;
        rstn = 1'b1;
        repeat (2) tick();
        chk("post_rst_ready", ld_ready, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_crst", core_rstn, 0);
        chk("post_rst_words", words_loaded, 0);

        // Randomized loads and runs.
        for (int it = 0; it < 8; it++) begin
            bit ul;
            int n;
            int mode;
            ul = 1'($urandom_range(0, 1));
            n  = ul ? $urandom_range(1, DEPTH) : $urandom_range(DEPTH, DEPTH + 2);
            for (int i = 0; i < 8; i++) ld_words[i] = $urandom;
            load_prog(n, ul, $urandom_range(0, 2));
            mode = $urandom_range(0, 2);
            if (mode == 0) build_halt(core_pc, $urandom_range(HC - 1, TMO - 1));
            else if (mode == 1) build_random();
            else build_spin();
            do_run();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter XLEN, default 64, core PC width.
REQ-002 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width (DEPTH = 2**ADDR_W words of 32 bits).
REQ-003 SHALL have parameter HALT_CYCLES, default 4, consecutive self-branch fetches that signal halt (range 1..255).
REQ-004 SHALL have parameter TIMEOUT, default 100000, maximum RUN cycles before abort (range 1..2**32-1).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a program load.
REQ-008 ld_valid  in  1  load beat valid.
REQ-009 ld_ready  out  1  loader accepts beat.
REQ-010 ld_data  in  32  instruction word.
REQ-011 ld_last  in  1  marks final beat of program.
REQ-012 im_we  out  1  instruction-memory write enable.
REQ-013 im_waddr  out  ADDR_W  instruction-memory word address.
REQ-014 im_wdata  out  32  instruction-memory write data.
REQ-015 core_rstn  out  1  active-low reset to processor core.
REQ-016 core_pc  in  XLEN  core program counter of current fetch.
REQ-017 core_instr  in  32  instruction fetched at core_pc.
REQ-018 busy  out  1  high in LOAD or RUN.
REQ-019 done  out  1  program halted normally.
REQ-020 timeout  out  1  RUN aborted by TIMEOUT.
REQ-021 trunc  out  1  DEPTH words accepted without ld_last.
REQ-022 cycles  out  32  RUN cycles elapsed.
REQ-023 words_loaded  out  ADDR_W+1  beats accepted in current load.

Function
REQ-024 SHALL implement states IDLE, LOAD, RUN, HALTED, TIMEDOUT.
REQ-025 IDLE/HALTED/TIMEDOUT: start=1 -> LOAD next cycle; words_loaded, cycles, done, timeout, trunc cleared on that edge.
REQ-026 start SHALL be ignored in LOAD and RUN.
REQ-027 ld_ready SHALL be 1 exactly while in LOAD (registered state decode, no combinational path from ld_valid).
REQ-028 Accepted beat (ld_valid & ld_ready) SHALL produce im_we=1, im_waddr=words_loaded (pre-increment), im_wdata=ld_data on the following cycle (1-cycle registered latency); im_we=0 otherwise.
REQ-029 Each accepted beat SHALL increment words_loaded by 1.
REQ-030 Accepted beat with ld_last=1 -> RUN next cycle.
REQ-031 Accepted beat at address DEPTH-1 with ld_last=0 -> RUN next cycle and trunc=1; no further beats accepted.
REQ-032 core_rstn SHALL be 0 in every state except RUN; it rises on the first cycle in RUN (after the final im_we write pulse has been issued).
REQ-033 In RUN, cycles SHALL increment by 1 every cycle, saturating at 2**32-1.
REQ-034 Halt detect: count consecutive RUN cycles with core_instr==32'h00000063 and core_pc equal to previous cycle's core_pc; any miss resets count to 0; count reaching HALT_CYCLES -> HALTED, done=1.
REQ-035 cycles reaching TIMEOUT while in RUN -> TIMEDOUT, timeout=1.
REQ-036 Halt and timeout on same cycle: halt SHALL win (HALTED, done=1, timeout=0).
REQ-037 cycles SHALL freeze in HALTED/TIMEDOUT until next start.
REQ-038 busy SHALL be 1 in LOAD and RUN, 0 otherwise.

Reset
REQ-039 rstn=0 SHALL immediately force IDLE and all outputs to 0 (core_rstn=0, ld_ready=0, im_we=0, counters 0), regardless of state, including mid-LOAD or mid-RUN.
REQ-040 After rstn deassert, block SHALL remain IDLE until start.

Verification
REQ-041 Load 3 words (A,B,C last) back-to-back -> im_we pulses at addr 0,1,2 with A,B,C one cycle after each accept; words_loaded=3; core_rstn=1 next cycle.
REQ-042 ld_valid gapped (1 beat every 3 cycles) -> identical memory contents, no extra im_we pulses.
REQ-043 RUN with core_instr=0x00000063 and constant core_pc=0x40 for 4 cycles -> done=1, core_rstn=0, cycles frozen.
REQ-044 TIMEOUT=50, core never halts -> timeout=1 after cycles=50; then start -> LOAD with all flags cleared.
REQ-045 ADDR_W=2, send 5 beats without ld_last -> 4 writes (addr 0..3), trunc=1, ld_ready=0 for 5th beat.
REQ-046 rstn pulsed low mid-RUN -> core_rstn=0 and all outputs 0 immediately (async), IDLE after release.
